// File: rtl/pdecoder_grant_2x4_pkg.sv
// Shared state encoding and default parameters for the priority-grant decoder.
package pdecoder_grant_2x4_pkg;

    localparam int unsigned CODE_W_DEF   = 2;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index-to-one-hot decoder with enable; all zeros when disabled.
module decoder_onehot
    import pdecoder_grant_2x4_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-1:0]      code,
    input  logic                   en,
    output logic [2**CODE_W-1:0]   onehot_c
);

    localparam int unsigned GW = 2**CODE_W;

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c = GW'(1) << code;
        end
    end

endmodule

// File: rtl/pdecoder_grant_2x4.sv
// Registered priority-grant decoder: captures an encoded index, holds a one-hot
// grant until done or hold timeout, then inserts a one-cycle gap.
module pdecoder_grant_2x4
    import pdecoder_grant_2x4_pkg::*;
#(
    parameter int unsigned CODE_W   = CODE_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CODE_W-1:0]     Q_in,
    input  logic                  v_in,
    input  logic                  done,
    output logic [2**CODE_W-1:0]  grant,
    output logic                  busy,
    output logic                  timeout
);

    localparam int unsigned GW    = 2**CODE_W;
    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_HOLD - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic                timeout_d;
    logic [CODE_W-1:0]   dec_code;
    logic                dec_en;
    logic [GW-1:0]       dec_onehot_c;

    decoder_onehot #(.CODE_W(CODE_W)) u_dec (
        .code     (dec_code),
        .en       (dec_en),
        .onehot_c (dec_onehot_c)
    );

    // Next-state, hold counter and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        dec_code  = idx_q;
        dec_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (v_in) begin
                    state_d  = S_GRANT;
                    idx_d    = Q_in;
                    dec_code = Q_in;
                    dec_en   = 1'b1;
                    cnt_d    = CNT_LOAD;
                end
            end
            S_GRANT: begin
                if (done) begin
                    state_d = S_GAP;
                end else if (cnt_q == '0) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    dec_en = 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            grant   <= dec_onehot_c;
            busy    <= (state_d != S_IDLE);
            timeout <= timeout_d;
        end
    end

endmodule
